// File: rtl/ext_pipe.sv
// Buffered immediate extender: extends IN_W-bit immediates to OUT_W bits and queues results in an in-order FIFO.
// Optional push/illegal-op statistics counters are enabled by defining EXT_PIPE_STAT_EN.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef EXT_PIPE_STAT_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = OUT_W - IN_W;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [OUT_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic             mem_err  [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [OUT_W-1:0] zext, sext, ext_data;
  logic             ext_err;

  // Wrap bit distinguishes full from empty when the indices coincide.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push = in_valid && !full;
  assign pop  = out_valid && out_ready;

  assign zext = {{EW{1'b0}}, in_imm};
  assign sext = {{EW{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_op)
      3'd0:    ext_data = zext;
      3'd1:    ext_data = sext;
      3'd2:    ext_data = {in_imm, {EW{1'b0}}};
      3'd3:    ext_data = sext << 2;
      3'd4:    ext_data = zext << 2;
      default: ext_err  = 1'b1;
    endcase
  end

  // Storage is cleared on reset so the head outputs read 0 rather than X while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr[AW-1:0]] <= ext_data;
        mem_tag[wr_ptr[AW-1:0]]  <= in_tag;
        mem_err[wr_ptr[AW-1:0]]  <= ext_err;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign out_data = mem_data[rd_ptr[AW-1:0]];
  assign out_tag  = mem_tag[rd_ptr[AW-1:0]];
  assign out_err  = mem_err[rd_ptr[AW-1:0]];

`ifdef EXT_PIPE_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_err <= '0;
    end else if (push) begin
      stat_ops <= stat_ops + 32'd1;
      if (ext_err) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: table-driven op vectors plus back-pressure, streaming and reset sequences.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;
`ifdef EXT_PIPE_STAT_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_err;
`endif

  int n_pass = 0;
  int n_total = 0;

  ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_err(out_err)
`ifdef EXT_PIPE_STAT_EN
    , .stat_ops(stat_ops), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] imm;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] imm, input logic [3:0] tag);
    in_valid = v;
    in_op    = op;
    in_imm   = imm;
    in_tag   = tag;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 16'h8001, 4'h1, 32'hFFFF8001, 1'b0};
    vecs[1]  = '{3'd0, 16'h8001, 4'h2, 32'h00008001, 1'b0};
    vecs[2]  = '{3'd2, 16'h1234, 4'h3, 32'h12340000, 1'b0};
    vecs[3]  = '{3'd3, 16'hFFFF, 4'h4, 32'hFFFFFFFC, 1'b0};
    vecs[4]  = '{3'd4, 16'h8000, 4'h5, 32'h00020000, 1'b0};
    vecs[5]  = '{3'd6, 16'h1234, 4'h6, 32'h00000000, 1'b1};
    vecs[6]  = '{3'd1, 16'h7FFF, 4'h7, 32'h00007FFF, 1'b0};
    vecs[7]  = '{3'd3, 16'h8000, 4'h8, 32'hFFFE0000, 1'b0};
    vecs[8]  = '{3'd4, 16'hFFFF, 4'h9, 32'h0003FFFC, 1'b0};
    vecs[9]  = '{3'd5, 16'h0000, 4'hA, 32'h00000000, 1'b1};
    vecs[10] = '{3'd7, 16'hFFFF, 4'hB, 32'h00000000, 1'b1};
    vecs[11] = '{3'd2, 16'hFFFF, 4'hC, 32'hFFFF0000, 1'b0};
    vecs[12] = '{3'd0, 16'h0000, 4'hD, 32'h00000000, 1'b0};
    vecs[13] = '{3'd3, 16'h0001, 4'hE, 32'h00000004, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 4'h0);
    out_ready = 1'b0;
    #22 rst_n = 1'b1;
    tick();

    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_data",  out_data,       32'h0);
    check("reset out_tag",   32'(out_tag),   32'd0);
    check("reset out_err",   32'(out_err),   32'd0);

    // Single pushes with out_ready high: visible next cycle, gone the cycle after.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].imm, vecs[i].tag);
      tick();
      drive(1'b0, 3'd0, 16'hDEAD, 4'hF);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d data", i),  out_data,       vecs[i].data);
      check($sformatf("vec%0d tag", i),   32'(out_tag),   32'(vecs[i].tag));
      check($sformatf("vec%0d err", i),   32'(out_err),   32'(vecs[i].err));
      tick();
      check($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
    end

    // Back-pressure: fill both entries, third request must wait.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0011, 4'h1);
    tick();
    check("bp ready after 1", 32'(in_ready), 32'd1);
    drive(1'b1, 3'd0, 16'h0022, 4'h2);
    tick();
    check("bp ready after 2", 32'(in_ready), 32'd0);
    check("bp head data 2",   out_data,      32'h00000011);
    drive(1'b1, 3'd0, 16'h0033, 4'h3);
    tick();
    check("bp full ready",    32'(in_ready), 32'd0);
    check("bp stable data",   out_data,      32'h00000011);
    check("bp stable tag",    32'(out_tag),  32'd1);
    out_ready = 1'b1;
    tick();
    check("bp pop1 data",     out_data,      32'h00000022);
    check("bp pop1 tag",      32'(out_tag),  32'd2);
    check("bp pop1 ready",    32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 3'd0, 16'h0, 4'h0);
    check("bp third data",    out_data,      32'h00000033);
    check("bp third tag",     32'(out_tag),  32'd3);
    check("bp third valid",   32'(out_valid), 32'd1);
    tick();
    check("bp drained",       32'(out_valid), 32'd0);

    // Continuous push and pop: occupancy stays at one, pointers wrap several times.
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 16'h0100, 4'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("stream%0d data", k),  out_data,        32'h00000100 + 32'(k - 1));
      check($sformatf("stream%0d tag", k),   32'(out_tag),    32'((k - 1) % 16));
      check($sformatf("stream%0d valid", k), 32'(out_valid),  32'd1);
      check($sformatf("stream%0d ready", k), 32'(in_ready),   32'd1);
      if (k < 10) drive(1'b1, 3'd0, 16'h0100 + 16'(k), 4'(k));
      else drive(1'b0, 3'd0, 16'h0, 4'h0);
    end
    tick();
    check("stream drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with two entries queued.
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 16'hAAAA, 4'h5);
    tick();
    drive(1'b1, 3'd1, 16'hBBBB, 4'h6);
    tick();
    drive(1'b0, 3'd0, 16'h0, 4'h0);
    check("prerst valid", 32'(out_valid), 32'd1);
    check("prerst ready", 32'(in_ready),  32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async valid", 32'(out_valid), 32'd0);
    check("rst async ready", 32'(in_ready),  32'd1);
    check("rst async data",  out_data,       32'h0);
    check("rst async tag",   32'(out_tag),   32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("postrst valid", 32'(out_valid), 32'd0);
    drive(1'b1, 3'd2, 16'h00C3, 4'h9);
    tick();
    drive(1'b0, 3'd0, 16'h0, 4'h0);
    check("postrst data", out_data,     32'h00C30000);
    check("postrst tag",  32'(out_tag), 32'd9);
    out_ready = 1'b1;
    tick();
    check("postrst drained", 32'(out_valid), 32'd0);

`ifdef EXT_PIPE_STAT_EN
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("stat ops reset", stat_ops,       32'd0);
    check("stat err reset", 32'(stat_err),  32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 1 || i == 3) ? 3'd5 : 3'd0, 16'(i), 4'(i));
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 4'h0);
    check("stat ops", stat_ops,      32'd5);
    check("stat err", 32'(stat_err), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
